// File: rtl/alu_8bit.sv
// alu_8bit: single-cycle registered 8-bit ALU.
//
// Samples Opcode/Operand1/Operand2 on every rising clk edge where in_valid
// is high and presents the registered Result and flags one cycle later,
// with out_valid pulsed for that cycle. When in_valid is low, Result and
// flags hold and out_valid drops. Back-to-back operations are accepted
// every cycle.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   sample operands/opcode this edge
//   Opcode     in   3   000 ADD, 001 SUB, 010 MUL, 011 AND,
//                       100 OR, 101 XOR, 110 SHL, 111 SHR
//   Operand1   in   8   operand A (unsigned)
//   Operand2   in   8   operand B (unsigned)
//   Result     out 16   registered result
//   flagC      out  1   registered carry/borrow/overflow
//   flagZ      out  1   registered zero flag (full 16-bit Result == 0)
//   out_valid  out  1   one-cycle pulse when Result/flags were updated
//
// Configuration:
//   ALU_8BIT_MUL_EN  defined   -> MUL returns the 16-bit product.
//                    undefined -> no multiplier; MUL returns 0, flagC 0.

module alu_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  Opcode,
  input  logic [7:0]  Operand1,
  input  logic [7:0]  Operand2,
  output logic [15:0] Result,
  output logic        flagC,
  output logic        flagZ,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_e;

  opcode_e     op;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] op_res;
  logic        op_c;

  logic [15:0] result_d, result_q;
  logic        flag_c_d, flag_c_q;
  logic        flag_z_d, flag_z_q;
  logic        out_valid_d, out_valid_q;

  assign op = opcode_e'(Opcode);

  // Widened to 9 bits so bit 8 carries the carry-out (ADD) or the
  // borrow (SUB: bit 8 is set exactly when A < B).
  assign sum9  = {1'b0, Operand1} + {1'b0, Operand2};
  assign diff9 = {1'b0, Operand1} - {1'b0, Operand2};

`ifdef ALU_8BIT_MUL_EN
  logic [15:0] product;
  assign product = Operand1 * Operand2;
`endif

  // Combinational operation result, independent of in_valid.
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    case (op)
      OP_ADD: begin
        op_res = {7'b0, sum9};
        op_c   = sum9[8];
      end
      OP_SUB: begin
        op_res = {8'h00, diff9[7:0]};
        op_c   = diff9[8];
      end
      OP_MUL: begin
`ifdef ALU_8BIT_MUL_EN
        op_res = product;
        op_c   = |product[15:8];
`else
        op_res = '0;
        op_c   = 1'b0;
`endif
      end
      OP_AND: op_res = {8'h00, Operand1 & Operand2};
      OP_OR:  op_res = {8'h00, Operand1 | Operand2};
      OP_XOR: op_res = {8'h00, Operand1 ^ Operand2};
      OP_SHL: begin
        op_res = {7'b0, Operand1, 1'b0};
        op_c   = Operand1[7];
      end
      OP_SHR: begin
        op_res = {8'h00, 1'b0, Operand1[7:1]};
        op_c   = Operand1[0];
      end
      default: begin
        op_res = '0;
        op_c   = 1'b0;
      end
    endcase
  end

  // Output registers load only on accepted operations; otherwise hold.
  always_comb begin
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = op_res;
      flag_c_d    = op_c;
      flag_z_d    = (op_res == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Result    = result_q;
  assign flagC     = flag_c_q;
  assign flagZ     = flag_z_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: a behavioural reference model checked
// every cycle, directed literal cases, reset cases, and randomized traffic.
module tb_alu_8bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  Opcode;
  logic [7:0]  Operand1;
  logic [7:0]  Operand2;
  logic [15:0] Result;
  logic        flagC;
  logic        flagZ;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .Opcode   (Opcode),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result   (Result),
    .flagC    (flagC),
    .flagZ    (flagZ),
    .out_valid(out_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {carry, result} from plain integer arithmetic.
  function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r, c;
    ia = a; ib = b; r = 0; c = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255) ? 1 : 0; end
      3'd1: begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
      3'd2: begin
`ifdef ALU_8BIT_MUL_EN
        r = ia * ib; c = (r > 255) ? 1 : 0;
`else
        r = 0; c = 0;
`endif
      end
      3'd3: r = int'(a & b);
      3'd4: r = int'(a | b);
      3'd5: r = int'(a ^ b);
      3'd6: begin r = ia * 2; c = (ia >= 128) ? 1 : 0; end
      default: begin r = ia / 2; c = ia % 2; end
    endcase
    return {c[0], r[15:0]};
  endfunction

  logic [15:0] m_res = '0;
  logic        m_c = 0, m_z = 0, m_v = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [16:0] rv;
    if (!rst_n) begin
      m_res <= '0; m_c <= 0; m_z <= 0; m_v <= 0;
    end else if (in_valid) begin
      rv = ref_op(Opcode, Operand1, Operand2);
      m_res <= rv[15:0];
      m_c   <= rv[16];
      m_z   <= (rv[15:0] == 16'd0);
      m_v   <= 1;
    end else begin
      m_v <= 0;
    end
  end

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_result",    Result,           m_res);
      check("model_flagC",     {15'd0, flagC},     {15'd0, m_c});
      check("model_flagZ",     {15'd0, flagZ},     {15'd0, m_z});
      check("model_out_valid", {15'd0, out_valid}, {15'd0, m_v});
    end
  end

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic v);
    @(negedge clk);
    Opcode = op; Operand1 = a; Operand2 = b; in_valid = v;
  endtask

  // Drive one op, then check literal outputs just after the sampling edge.
  task automatic op_lit(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic ec, input logic ez);
    drive(op, a, b, 1'b1);
    @(posedge clk); #1;
    check({name, "_res"}, Result, er);
    check({name, "_c"},   {15'd0, flagC},     {15'd0, ec});
    check({name, "_z"},   {15'd0, flagZ},     {15'd0, ez});
    check({name, "_v"},   {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    rst_n = 1; in_valid = 0; Opcode = '0; Operand1 = '0; Operand2 = '0;
    #1 rst_n = 0;
    #2;
    check("reset_result", Result, 16'd0);
    check("reset_flags", {13'd0, flagC, flagZ, out_valid}, 16'd0);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;

    op_lit("add_aa_cc", 3'd0, 8'hAA, 8'hCC, 16'h0176, 1, 0);
    op_lit("add_ff_01", 3'd0, 8'hFF, 8'h01, 16'h0100, 1, 0);
    op_lit("sub_cc_aa", 3'd1, 8'hCC, 8'hAA, 16'h0022, 0, 0);
    op_lit("sub_10_20", 3'd1, 8'h10, 8'h20, 16'h00F0, 1, 0);
    op_lit("sub_eq",    3'd1, 8'h5A, 8'h5A, 16'h0000, 0, 1);
`ifdef ALU_8BIT_MUL_EN
    op_lit("mul_55_33", 3'd2, 8'h55, 8'h33, 16'h10EF, 1, 0);
    op_lit("mul_ff_ff", 3'd2, 8'hFF, 8'hFF, 16'hFE01, 1, 0);
    op_lit("mul_zero",  3'd2, 8'h00, 8'h7B, 16'h0000, 0, 1);
`else
    op_lit("mul_off",   3'd2, 8'h55, 8'h33, 16'h0000, 0, 1);
`endif
    op_lit("and_cc_aa", 3'd3, 8'hCC, 8'hAA, 16'h0088, 0, 0);
    op_lit("or_cc_aa",  3'd4, 8'hCC, 8'hAA, 16'h00EE, 0, 0);
    op_lit("xor_cc_aa", 3'd5, 8'hCC, 8'hAA, 16'h0066, 0, 0);
    op_lit("shl_81",    3'd6, 8'h81, 8'h3C, 16'h0102, 1, 0);
    op_lit("shr_01",    3'd7, 8'h01, 8'hF0, 16'h0000, 1, 1);

    // Hold: in_valid low keeps Result/flags, drops out_valid.
    drive(3'd0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    check("hold_result", Result, 16'h0000);
    check("hold_flagZ", {15'd0, flagZ}, 16'd1);
    check("hold_out_valid", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset between edges after a valid ADD.
    op_lit("add_pre_rst", 3'd0, 8'h01, 8'h01, 16'h0002, 0, 0);
    #2 rst_n = 0;
    #1;
    check("async_rst_result", Result, 16'd0);
    check("async_rst_flags", {13'd0, flagC, flagZ, out_valid}, 16'd0);
    drive(3'd0, 8'h40, 8'h40, 1'b1);   // pending op during reset is discarded
    drive(3'd0, 8'h40, 8'h40, 1'b0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_result", Result, 16'd0);
    check("post_rst_flags", {13'd0, flagC, flagZ, out_valid}, 16'd0);

    // Randomized traffic, biased towards boundary operand values.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 7))
        0: a = 8'h00;
        1: b = 8'h00;
        2: a = 8'hFF;
        3: b = 8'hFF;
        4: b = a;
        default: ;
      endcase
      drive(3'($urandom), a, b, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 63) == 0) begin
        #3 rst_n = 0;
        @(negedge clk);
        #1 rst_n = 1;
      end
    end

    drive(3'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
